// File: rtl/hd_timing_pkg.sv
// hd_timing_pkg: shared widths, raster presets and genlock state type for the HD timing generator
//   HPOS_W/VPOS_W : pixel column / line counter widths
//   DIV_W         : width of the pixel-clock divider counter (CLK_DIV up to 63)
//   H_720P/V_720P, H_1080P/V_1080P : horizontal/vertical raster presets
package hd_timing_pkg;

    localparam int HPOS_W = 12;
    localparam int VPOS_W = 11;
    localparam int DIV_W  = 6;

    typedef struct packed {
        int act;
        int fp;
        int sync;
        int bp;
    } axis_t;

    localparam axis_t H_720P  = '{act: 1280, fp: 110, sync: 40, bp: 220};
    localparam axis_t V_720P  = '{act: 720,  fp: 5,   sync: 5,  bp: 20};
    localparam axis_t H_1080P = '{act: 1920, fp: 88,  sync: 44, bp: 148};
    localparam axis_t V_1080P = '{act: 1080, fp: 4,   sync: 5,  bp: 36};

    typedef enum logic {
        LOCK_IDLE,
        LOCK_PENDING
    } lock_state_t;

    function automatic int axis_total(axis_t a);
        return a.act + a.fp + a.sync + a.bp;
    endfunction

endpackage

// File: rtl/hd_timing_gen_if.sv
// hd_timing_gen_if: HD raster output bus from the timing generator to its consumers
//   o_hd_clk      : pixel clock
//   o_hd_hsync    : horizontal sync
//   o_hd_vsync    : vertical sync
//   o_hd_de       : active-video data enable
//   o_h_pos       : current pixel column
//   o_v_pos       : current line
//   o_frame_start : one-clk pulse on the step to pixel (0,0)
interface hd_timing_gen_if;
    import hd_timing_pkg::*;

    logic              o_hd_clk;
    logic              o_hd_hsync;
    logic              o_hd_vsync;
    logic              o_hd_de;
    logic [HPOS_W-1:0] o_h_pos;
    logic [VPOS_W-1:0] o_v_pos;
    logic              o_frame_start;

    modport master (
        output o_hd_clk, o_hd_hsync, o_hd_vsync, o_hd_de, o_h_pos, o_v_pos, o_frame_start
    );

    modport slave (
        input o_hd_clk, o_hd_hsync, o_hd_vsync, o_hd_de, o_h_pos, o_v_pos, o_frame_start
    );

endinterface

// File: rtl/hd_pix_clk_div.sv
// hd_pix_clk_div: divides clk into the 50% duty pixel clock and flags the pixel step
//   clk, rst_n : system clock, asynchronous active-low reset
//   hd_clk     : pixel clock, toggles every CLK_DIV clk cycles
//   pix_step   : high during the clk cycle whose closing edge takes hd_clk 1->0
module hd_pix_clk_div
    import hd_timing_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    output logic hd_clk,
    output logic pix_step
);

    logic [DIV_W-1:0] div_cnt;
    logic             div_wrap;

    always_comb begin
        div_wrap = int'(div_cnt) == CLK_DIV - 1;
        pix_step = div_wrap && hd_clk;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            hd_clk  <= 1'b0;
        end else begin
            div_cnt <= div_wrap ? '0 : div_cnt + DIV_W'(1);
            hd_clk  <= hd_clk ^ div_wrap;
        end
    end

endmodule

// File: rtl/hd_timing_gen.sv
// hd_timing_gen: HD raster timing (pixel clock, syncs, DE, coordinates) with PAL genlock realign
//   clk, rst_n  : system clock, asynchronous active-low reset
//   i_lock_en   : genlock enable
//   i_frame_end : one-clk pulse marking a PAL frame end
//   vid         : raster output bus (hd_timing_gen_if.master)
module hd_timing_gen
    import hd_timing_pkg::*;
#(
    parameter int H_ACTIVE  = H_720P.act,
    parameter int H_FP      = H_720P.fp,
    parameter int H_SYNC    = H_720P.sync,
    parameter int H_BP      = H_720P.bp,
    parameter int V_ACTIVE  = V_720P.act,
    parameter int V_FP      = V_720P.fp,
    parameter int V_SYNC    = V_720P.sync,
    parameter int V_BP      = V_720P.bp,
    parameter int CLK_DIV   = 1,
    parameter bit HS_POL    = 1'b1,
    parameter bit VS_POL    = 1'b1,
    parameter int LOCK_LINE = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_lock_en,
    input  logic            i_frame_end,
    hd_timing_gen_if.master vid
);

    localparam axis_t H_CFG   = '{act: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
    localparam axis_t V_CFG   = '{act: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};
    localparam int    H_TOTAL = axis_total(H_CFG);
    localparam int    V_TOTAL = axis_total(V_CFG);
    localparam int    HS_BEG  = H_ACTIVE + H_FP;
    localparam int    HS_END  = HS_BEG + H_SYNC;
    localparam int    VS_BEG  = V_ACTIVE + V_FP;
    localparam int    VS_END  = VS_BEG + V_SYNC;

    if (H_TOTAL > 4096 || V_TOTAL > 2048 || CLK_DIV < 1 || CLK_DIV > 63
        || LOCK_LINE < 0 || LOCK_LINE >= V_TOTAL) begin : g_bad_cfg
        $error("hd_timing_gen: raster or divider parameters out of range");
    end

    logic              pix_step;
    logic              h_wrap;
    logic              realign;
    logic [HPOS_W-1:0] h_cnt, h_nxt;
    logic [VPOS_W-1:0] v_cnt, v_nxt;
    lock_state_t       state, state_nxt;

    hd_pix_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .hd_clk   (vid.o_hd_clk),
        .pix_step (pix_step)
    );

    // Counter next values are computed every cycle but only committed on pix_step.
    always_comb begin
        h_wrap  = int'(h_cnt) == H_TOTAL - 1;
        realign = h_wrap && state == LOCK_PENDING && i_lock_en;
        h_nxt   = h_wrap ? '0 : h_cnt + HPOS_W'(1);
        v_nxt   = realign                     ? VPOS_W'(LOCK_LINE) :
                  !h_wrap                     ? v_cnt :
                  int'(v_cnt) == V_TOTAL - 1  ? '0 : v_cnt + VPOS_W'(1);
    end

    // Pending clears on the wrap that consumed it; frame-end pulses meanwhile are absorbed.
    always_comb begin
        state_nxt = !i_lock_en            ? LOCK_IDLE :
                    state == LOCK_IDLE    ? (i_frame_end ? LOCK_PENDING : LOCK_IDLE) :
                    (pix_step && h_wrap)  ? LOCK_IDLE : LOCK_PENDING;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= LOCK_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt             <= HPOS_W'(H_TOTAL - 1);
            v_cnt             <= VPOS_W'(V_TOTAL - 1);
            vid.o_hd_hsync    <= ~HS_POL;
            vid.o_hd_vsync    <= ~VS_POL;
            vid.o_hd_de       <= 1'b0;
            vid.o_h_pos       <= '0;
            vid.o_v_pos       <= '0;
            vid.o_frame_start <= 1'b0;
        end else begin
            vid.o_frame_start <= pix_step && h_nxt == '0 && v_nxt == '0;
            if (pix_step) begin
                h_cnt          <= h_nxt;
                v_cnt          <= v_nxt;
                vid.o_h_pos    <= h_nxt;
                vid.o_v_pos    <= v_nxt;
                vid.o_hd_de    <= int'(h_nxt) < H_ACTIVE && int'(v_nxt) < V_ACTIVE;
                vid.o_hd_hsync <= (int'(h_nxt) >= HS_BEG && int'(h_nxt) < HS_END) ? HS_POL : ~HS_POL;
                vid.o_hd_vsync <= (int'(v_nxt) >= VS_BEG && int'(v_nxt) < VS_END) ? VS_POL : ~VS_POL;
            end
        end
    end

endmodule

// File: tb/tb_hd_timing_gen.sv
// tb_hd_timing_gen: 720p/CLK_DIV=1 and reduced-raster/CLK_DIV=3 instances checked against a frame-position model
module tb_hd_timing_gen;

    localparam int N = 2;
    localparam int P_HA[N] = '{1280, 8};
    localparam int P_HF[N] = '{110, 2};
    localparam int P_HS[N] = '{40, 2};
    localparam int P_HB[N] = '{220, 2};
    localparam int P_VA[N] = '{720, 4};
    localparam int P_VF[N] = '{5, 1};
    localparam int P_VS[N] = '{5, 1};
    localparam int P_VB[N] = '{20, 1};
    localparam int P_CD[N] = '{1, 3};
    localparam bit P_HP[N] = '{1'b1, 1'b0};
    localparam bit P_VP[N] = '{1'b1, 1'b0};
    localparam int P_LL[N] = '{0, 2};

    logic         clk;
    logic         rst_n;
    logic [N-1:0] le;
    logic [N-1:0] fe;

    hd_timing_gen_if v0 ();
    hd_timing_gen_if v1 ();

    hd_timing_gen #(
        .H_ACTIVE(P_HA[0]), .H_FP(P_HF[0]), .H_SYNC(P_HS[0]), .H_BP(P_HB[0]),
        .V_ACTIVE(P_VA[0]), .V_FP(P_VF[0]), .V_SYNC(P_VS[0]), .V_BP(P_VB[0]),
        .CLK_DIV(P_CD[0]), .HS_POL(P_HP[0]), .VS_POL(P_VP[0]), .LOCK_LINE(P_LL[0])
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .i_lock_en(le[0]), .i_frame_end(fe[0]), .vid(v0)
    );

    hd_timing_gen #(
        .H_ACTIVE(P_HA[1]), .H_FP(P_HF[1]), .H_SYNC(P_HS[1]), .H_BP(P_HB[1]),
        .V_ACTIVE(P_VA[1]), .V_FP(P_VF[1]), .V_SYNC(P_VS[1]), .V_BP(P_VB[1]),
        .CLK_DIV(P_CD[1]), .HS_POL(P_HP[1]), .VS_POL(P_VP[1]), .LOCK_LINE(P_LL[1])
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .i_lock_en(le[1]), .i_frame_end(fe[1]), .vid(v1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: each instance is a position p = v*H_TOTAL + h within the frame,
    // plus the edge count k since reset release that decides the pixel clock.
    int k[N], p[N];
    bit pend[N];
    bit e_clk[N], e_hs[N], e_vs[N], e_de[N], e_fs[N];
    int e_h[N], e_v[N];

    function automatic int ht(int d);
        return P_HA[d] + P_HF[d] + P_HS[d] + P_HB[d];
    endfunction

    function automatic int vt(int d);
        return P_VA[d] + P_VF[d] + P_VS[d] + P_VB[d];
    endfunction

    task automatic chk(input int d, input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL dut%0d %s: got %0d expected %0d at %0t", d, tag, got, exp, $time);
        end
    endtask

    task automatic model_reset(input int d);
        k[d]     = 0;
        p[d]     = ht(d) * vt(d) - 1;
        pend[d]  = 1'b0;
        e_clk[d] = 1'b0;
        e_hs[d]  = ~P_HP[d];
        e_vs[d]  = ~P_VP[d];
        e_de[d]  = 1'b0;
        e_h[d]   = 0;
        e_v[d]   = 0;
        e_fs[d]  = 1'b0;
    endtask

    task automatic model_edge(input int d);
        int h, v;
        bit step, wrap, realign;
        k[d]++;
        e_clk[d] = ((k[d] / P_CD[d]) % 2) == 1;
        step     = (k[d] % (2 * P_CD[d])) == 0;
        wrap     = step && (p[d] % ht(d)) == ht(d) - 1;
        realign  = wrap && pend[d] && le[d];
        if (!le[d])
            pend[d] = 1'b0;
        else if (pend[d])
            pend[d] = !wrap;
        else
            pend[d] = fe[d];
        e_fs[d] = 1'b0;
        if (step) begin
            p[d]    = realign ? P_LL[d] * ht(d) : (p[d] + 1) % (ht(d) * vt(d));
            h       = p[d] % ht(d);
            v       = p[d] / ht(d);
            e_h[d]  = h;
            e_v[d]  = v;
            e_de[d] = h < P_HA[d] && v < P_VA[d];
            e_hs[d] = (h >= P_HA[d] + P_HF[d] && h < P_HA[d] + P_HF[d] + P_HS[d]) ? P_HP[d] : ~P_HP[d];
            e_vs[d] = (v >= P_VA[d] + P_VF[d] && v < P_VA[d] + P_VF[d] + P_VS[d]) ? P_VP[d] : ~P_VP[d];
            e_fs[d] = p[d] == 0;
        end
    endtask

    task automatic cmp(input int d, input logic c, input logic hs, input logic vs, input logic de,
                       input logic fs, input logic [11:0] h, input logic [10:0] v);
        chk(d, "hd_clk", c, e_clk[d]);
        chk(d, "hsync", hs, e_hs[d]);
        chk(d, "vsync", vs, e_vs[d]);
        chk(d, "de", de, e_de[d]);
        chk(d, "frame_start", fs, e_fs[d]);
        chk(d, "h_pos", h, e_h[d]);
        chk(d, "v_pos", v, e_v[d]);
    endtask

    task automatic cmp_all();
        cmp(0, v0.o_hd_clk, v0.o_hd_hsync, v0.o_hd_vsync, v0.o_hd_de, v0.o_frame_start, v0.o_h_pos, v0.o_v_pos);
        cmp(1, v1.o_hd_clk, v1.o_hd_hsync, v1.o_hd_vsync, v1.o_hd_de, v1.o_frame_start, v1.o_h_pos, v1.o_v_pos);
    endtask

    // Drive inputs at the falling edge, advance the model on the rising edge, compare at the next falling edge.
    task automatic cycle(input bit l0, input bit f0, input bit l1, input bit f1);
        le = {l1, l0};
        fe = {f1, f0};
        @(posedge clk);
        if (rst_n)
            for (int d = 0; d < N; d++) model_edge(d);
        @(negedge clk);
        cmp_all();
    endtask

    int de_n, hs_n, fs_n;

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, 1'b0, 1'b1, 1'b0);
            de_n += int'(v0.o_hd_de);
            hs_n += int'(v0.o_hd_hsync);
            fs_n += int'(v0.o_frame_start);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        le    = '0;
        fe    = '0;
        for (int d = 0; d < N; d++) model_reset(d);
        repeat (3) @(negedge clk);
        cmp_all();
        rst_n = 1'b1;

        de_n = 0; hs_n = 0; fs_n = 0;
        run(3301);
        chk(0, "line_de_samples", de_n, 2 * 1280);
        chk(0, "line_hsync_samples", hs_n, 2 * 40);
        chk(0, "line_frame_start", fs_n, 1);

        for (int n = 0; n < 4000 && p[0] != ht(0) + 500; n++) cycle(1'b1, 1'b0, 1'b1, 1'b0);
        chk(0, "at_h500", v0.o_h_pos, 500);
        chk(0, "at_v1", v0.o_v_pos, 1);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        for (int n = 0; n < 4000 && p[0] != ht(0) + 900; n++) cycle(1'b1, 1'b0, 1'b1, 1'b0);
        chk(0, "at_h900", v0.o_h_pos, 900);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        fs_n = 0;
        run(1600);
        chk(0, "lock_v", v0.o_v_pos, 0);
        chk(0, "lock_frame_start", fs_n, 1);
        run(3300);
        chk(0, "absorb_v", v0.o_v_pos, 1);
        chk(0, "absorb_frame_start", fs_n, 1);

        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        run(3300);
        chk(0, "nolock_v", v0.o_v_pos, 2);

        for (int i = 0; i < 20000; i++)
            cycle($urandom_range(0, 15) != 0, $urandom_range(0, 199) == 0,
                  $urandom_range(0, 15) != 0, $urandom_range(0, 59) == 0);

        for (int n = 0; n < 200 && (p[1] % ht(1)) != 5; n++) cycle(1'b1, 1'b0, 1'b1, 1'b0);
        chk(1, "pre_reset_h", v1.o_h_pos, 5);
        #2;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < N; d++) model_reset(d);
        cmp_all();
        @(negedge clk);
        repeat (3) cycle(1'b1, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 600; i++)
            cycle(1'b1, $urandom_range(0, 99) == 0, 1'b1, $urandom_range(0, 29) == 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
